// File: rtl/jk_q_monitor.sv
// rtl/jk_q_monitor.sv - edge/activity monitor for JK flip-flop q/q_bar outputs
// Counts q edges, flags a stuck q and flags loss of q/q_bar complementarity.
module jk_q_monitor #(
  parameter int CNT_W     = 8,
  parameter int STUCK_LIM = 16,
  parameter int COMPL_LIM = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             q,
  input  logic             q_bar,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             stuck,
  output logic             compl_err,
  output logic [1:0]       state
);

  localparam int ST_W  = $clog2(STUCK_LIM + 1);
  localparam int MIS_W = $clog2(COMPL_LIM + 1);
  localparam logic [ST_W-1:0]  ST_LIM  = ST_W'(STUCK_LIM);
  localparam logic [MIS_W-1:0] MIS_LIM = MIS_W'(COMPL_LIM);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t           st;
  logic             q_d;
  logic [ST_W-1:0]  st_tmr;
  logic [MIS_W-1:0] mis_tmr;
  logic [MIS_W-1:0] mis_inc;
  logic             same;

  assign state   = st;
  assign same    = (q == q_bar);
  assign mis_inc = mis_tmr + MIS_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      st         <= S_INIT;
      q_d        <= 1'b0;
      st_tmr     <= '0;
      mis_tmr    <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      stuck      <= 1'b0;
      compl_err  <= 1'b0;
    end else if (!en) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (st)
        S_INIT: begin
          q_d     <= q;
          st_tmr  <= '0;
          mis_tmr <= '0;
          st      <= S_TRACK;
        end
        S_TRACK: begin
          mis_tmr <= same ? mis_inc : '0;
          // A complementarity fault takes precedence over an edge on the same sample.
          if (same && mis_inc == MIS_LIM) begin
            compl_err <= 1'b1;
            st        <= S_FAULT;
          end else if (q != q_d) begin
            q_d    <= q;
            st_tmr <= '0;
            stuck  <= 1'b0;
            if (q) begin
              rise_pulse <= 1'b1;
              if (rise_cnt != CNT_MAX) rise_cnt <= rise_cnt + CNT_W'(1);
            end else begin
              fall_pulse <= 1'b1;
              if (fall_cnt != CNT_MAX) fall_cnt <= fall_cnt + CNT_W'(1);
            end
          end else begin
            if (st_tmr != ST_LIM) st_tmr <= st_tmr + ST_W'(1);
            if (st_tmr >= ST_LIM - ST_W'(1)) stuck <= 1'b1;
          end
        end
        S_FAULT: begin
          compl_err <= 1'b1;
        end
        default: st <= S_INIT;
      endcase
    end
  end

endmodule
